// File: rtl/fpdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpdiv_arbiter (with helper module fpdiv)
// Brief    : Round-robin sharing of one multicycle single-precision divider.
//            Optional macro FPDIV_ARB_SPECIAL_EN overrides divide-by-zero results.
// Revision : 1.0 - initial release
// ============================================================================

module fpdiv (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_q
);
    logic              w_sa, w_sb, w_s;
    logic [7:0]        w_ea, w_eb;
    logic [22:0]       w_fa, w_fb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [26:0]       w_quo;
    logic [23:0]       w_rem;
    logic [23:0]       w_m24;
    logic              w_guard, w_sticky;
    logic [24:0]       w_mr;
    logic signed [9:0] w_e;
    logic [22:0]       w_frac;

    assign w_sa     = i_a[31];
    assign w_sb     = i_b[31];
    assign w_s      = w_sa ^ w_sb;
    assign w_ea     = i_a[30:23];
    assign w_eb     = i_b[30:23];
    assign w_fa     = i_a[22:0];
    assign w_fb     = i_b[22:0];
    // Subnormal operands are flushed to zero.
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'h0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'h0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'h0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'h0);

    always_comb begin
        w_quo    = 27'(({1'b1, w_fa, 26'h0}) / {26'h0, 1'b1, w_fb});
        w_rem    = 24'(({1'b1, w_fa, 26'h0}) % {26'h0, 1'b1, w_fb});
        w_m24    = w_quo[26] ? w_quo[26:3] : w_quo[25:2];
        w_guard  = w_quo[26] ? w_quo[2] : w_quo[1];
        w_sticky = (w_quo[26] ? (|w_quo[1:0]) : w_quo[0]) | (w_rem != 24'h0);
        w_mr     = {1'b0, w_m24} + 25'(w_guard & (w_sticky | w_m24[0]));
        w_e      = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                   + (w_quo[26] ? 10'sd127 : 10'sd126);
        w_frac   = w_mr[22:0];
        if (w_mr[24]) begin
            w_e    = w_e + 10'sd1;
            w_frac = w_mr[23:1];
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero))
            o_q = 32'h7FC0_0000;
        else if (w_a_inf || w_b_zero)
            o_q = {w_s, 8'hFF, 23'h0};
        else if (w_a_zero || w_b_inf)
            o_q = {w_s, 31'h0};
        else if (w_e >= 10'sd255)
            o_q = {w_s, 8'hFF, 23'h0};
        else if (w_e <= 10'sd0)
            o_q = {w_s, 31'h0};
        else
            o_q = {w_s, w_e[7:0], w_frac};
    end
endmodule

module fpdiv_arbiter #(
    parameter int NREQ        = 4,
    parameter int CALC_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_dividend,
    input  logic [NREQ*32-1:0]      req_divisor,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_quotient,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    resp_dz,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_load = CW'(CALC_CYCLES - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_id;
    logic [31:0]    r_a, r_b, r_res;
    logic           r_dz;

    logic [31:0]    w_dividend [NREQ];
    logic [31:0]    w_divisor  [NREQ];
    logic [IDW-1:0] w_grant;
    logic           w_any;
    logic [31:0]    w_fpdiv_q;
    logic [31:0]    w_res;
    logic           w_dz;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_dividend[i] = req_dividend[32*i +: 32];
            assign w_divisor[i]  = req_divisor[32*i +: 32];
        end
    endgenerate

    // Scan from the highest offset down so the nearest valid requester to r_rr wins.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr) + k) % NREQ]) begin
                w_grant = IDW'((int'(r_rr) + k) % NREQ);
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset_n && (r_state == c_idle) && w_any)
            req_ready[w_grant] = 1'b1;
    end

    fpdiv u_fpdiv (
        .i_a (r_a),
        .i_b (r_b),
        .o_q (w_fpdiv_q)
    );

`ifdef FPDIV_ARB_SPECIAL_EN
    always_comb begin
        w_res = w_fpdiv_q;
        w_dz  = 1'b0;
        if (r_b[30:0] == 31'h0) begin
            if (r_a[30:0] != 31'h0) begin
                w_res = {r_a[31] ^ r_b[31], 8'hFF, 23'h0};
                w_dz  = 1'b1;
            end else begin
                w_res = 32'h7FC0_0000;
            end
        end
    end
`else
    assign w_res = w_fpdiv_q;
    assign w_dz  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_a     <= w_dividend[w_grant];
                        r_b     <= w_divisor[w_grant];
                        r_id    <= w_grant;
                        r_rr    <= IDW'((int'(w_grant) + 1) % NREQ);
                        r_cnt   <= c_cnt_load;
                        r_state <= c_calc;
                    end
                end
                c_calc: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_res   <= w_res;
                        r_dz    <= w_dz;
                        r_state <= c_resp;
                    end
                end
                c_resp: begin
                    if (resp_ready)
                        r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign resp_valid    = (r_state == c_resp);
    assign resp_quotient = r_res;
    assign resp_id       = r_id;
    assign resp_dz       = r_dz;
    assign busy          = (r_state != c_idle);
endmodule

`default_nettype wire

// File: doc/fpdiv_arbiter.md
# fpdiv_arbiter

Shares a single `fpdiv` single-precision divider among `NREQ` requesters. Arbitration is round-robin. Each requester uses a valid/ready request channel, and all requesters share one valid/ready response channel. Operands are registered before the divider, and the divider's combinational path gets a fixed multicycle window of `CALC_CYCLES` clocks. The block sits between the core's FP issue ports and the `fpdiv` datapath, and is the only instantiator of `fpdiv` in the FP unit.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be ≥2.
- `CALC_CYCLES`, 2: clocks allowed for the `fpdiv` combinational path; must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `req_valid`, input, `NREQ`: request pending, one bit per requester.
- `req_ready`, output, `NREQ`: request accepted this cycle (one-hot or zero).
- `req_dividend`, input, `NREQ*32`: IEEE-754 single dividends; requester i uses bits `[32i+31:32i]`.
- `req_divisor`, input, `NREQ*32`: divisors, packed the same way as `req_dividend`.
- `resp_valid`, output, 1: result available.
- `resp_ready`, input, 1: consumer takes the result.
- `resp_quotient`, output, 32: quotient.
- `resp_id`, output, `$clog2(NREQ)`: index of the requester the result belongs to.
- `resp_dz`, output, 1: divide-by-zero flag (see Configuration).
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
The FSM has three states: IDLE, CALC, RESP.
- **Operand and result registers:** `a_q`, `b_q`, `id_q`, `res_q`, `dz_q`, plus a round-robin pointer `rr_q`.
- **IDLE:**
  - `grant` is the first index i with `req_valid[i]=1`, searching i = `rr_q`, `rr_q+1`, … modulo `NREQ`.
  - `req_ready[grant]=1`; all other ready bits are 0. `req_ready` depends combinationally on `req_valid` and `rr_q` only.
  - On a handshake: capture the granted operands into `a_q`/`b_q`, capture `grant` into `id_q`, set `rr_q ← (grant+1) mod NREQ`, load the counter with `CALC_CYCLES-1`, and go to CALC.
  - With no valid request, stay in IDLE and leave `rr_q` unchanged.
- **CALC:**
  - `fpdiv` is driven only from `a_q`/`b_q`.
  - While the counter is nonzero, decrement it.
  - At 0: `res_q ← fpdiv quotient` (or the special value), set `dz_q`, and go to RESP.
  - All `req_ready` bits are 0.
- **RESP:**
  - `resp_valid=1`. `resp_quotient`, `resp_id` and `resp_dz` are driven from registers and stay stable until the handshake.
  - On `resp_ready=1`, go to IDLE.
  - No new request is accepted in RESP, including in the handshake cycle.
- **Outputs outside RESP:** `resp_valid=0`; `resp_quotient`, `resp_id` and `resp_dz` hold their last values.
- **Sign handling:** none here. Sign, exponent and mantissa come entirely from `fpdiv`; the arbiter does no arithmetic except in the special path.

## Timing
- **Latency:** request handshake at edge T → `resp_valid` high in the cycle after edge T+`CALC_CYCLES`. This is `CALC_CYCLES+1` cycles after the accept.
- **Throughput:** with `resp_ready` tied high, one operation per `CALC_CYCLES+2` cycles.
- **Fairness:** with all requesters continuously valid, service order is 0,1,…,`NREQ-1`,0,…. No requester waits more than `NREQ-1` other operations.
- **Reset mid-operation:** when `reset_n=0` at an edge, any in-flight operation is discarded and no response is produced.
- **Reset values:**
  - State IDLE, `rr_q=0`, counter 0.
  - `resp_valid=0`, `resp_quotient=0`, `resp_id=0`, `resp_dz=0`, `busy=0`.
  - `req_ready` is combinational from the reset state: it is 0 while `reset_n=0`.
- **Operand stability:** request operands need to be stable only in the handshake cycle.

## Configuration
Macro: `FPDIV_ARB_SPECIAL_EN`.
- **Defined:** the CALC capture overrides the `fpdiv` result when the divisor is ±0 (exponent 0 and mantissa 0):
  - Dividend nonzero: quotient `{sa^sb, 8'hFF, 23'h0}` (infinity), `resp_dz=1`.
  - Dividend ±0: quotient `32'h7FC00000`, `resp_dz=0`.
- **Undefined:** the raw `fpdiv` output is captured unchanged, and `resp_dz` is tied to 0.

## Test plan
- **Basic divide:** requester 0 sends `0x40C00000 / 0x40000000` with `CALC_CYCLES=2` → `resp_quotient=0x40400000`, `resp_id=0`, `resp_valid` rising 3 cycles after the accept.
- **Round-robin:** all 4 requesters held valid, each with `0x3F800000 / 0x40000000`, and `resp_ready=1` → `resp_id` sequence 0,1,2,3,0; every quotient `0x3F000000`; accepts spaced 4 cycles apart.
- **Backpressure:** `resp_ready=0` for 5 cycles after `resp_valid` rises → response stays stable, `req_ready` all 0, `busy=1`; release → IDLE the next cycle.
- **Reset in CALC:** `reset_n` pulled low in the first CALC cycle → all outputs at reset values, no response, next accept goes to requester 0.
- **Divide by zero, macro defined:** `0xBF800000 / 0x00000000` → `0xFF800000`, `resp_dz=1`. `0x00000000 / 0x80000000` → `0x7FC00000`, `resp_dz=0`.
- **Divide by zero, macro undefined:** same stimulus → `resp_dz=0`, quotient equal to the standalone `fpdiv` output.
